// File: rtl/md_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_pkg : shared op encoding, FSM state type and default latencies for the
//          HI/LO multiply/divide unit.                               rev 1.0
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_calc : combinational 64-bit multiply / divide datapath.        rev 1.0
// ---------------------------------------------------------------------------
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sdiv;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_out;
  logic [31:0] r_out;

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide runs on magnitudes; 0x80000000 / -1 then falls out as
  // 0x80000000 rem 0 without any special case.
  assign sdiv  = (op == MD_DIV);
  assign a_mag = (sdiv && rs[31]) ? (~rs + 32'd1) : rs;
  assign b_mag = (sdiv && rt[31]) ? (~rt + 32'd1) : rt;
  assign neg_q = sdiv && (rs[31] ^ rt[31]);
  assign neg_r = sdiv && rs[31];

  assign div0    = is_div(op) && (rt == 32'd0);
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign q_out   = neg_q ? (~q_mag + 32'd1) : q_mag;
  assign r_out   = neg_r ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {r_out, q_out};
      MD_DIVU:  result = {r_mag, q_mag};
      default:  result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_ctrl : multi-cycle HI/LO unit with busy FSM and hazard stall.  rev 1.0
// ---------------------------------------------------------------------------
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ex_md_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        id_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_state_e   state;
  md_state_e   state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        start;
  logic        done;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_div0;
  logic [63:0] calc_res;
  logic        calc_div0;

  md_calc u_calc (
    .op     (ex_md_op),
    .rs     (ex_rs),
    .rt     (ex_rt),
    .result (calc_res),
    .div0   (calc_div0)
  );

  assign start = (state == ST_IDLE) && is_arith(ex_md_op);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = is_div(ex_md_op) ? DIV_LOAD : MULT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Result is captured at start so EX operands may change while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_hi   <= 32'd0;
      res_lo   <= 32'd0;
      res_div0 <= 1'b0;
    end else if (start) begin
      res_hi   <= calc_res[63:32];
      res_lo   <= calc_res[31:0];
      res_div0 <= calc_div0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (!res_div0) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (state == ST_IDLE) begin
      if (ex_md_op == MD_MTHI) hi <= ex_rs;
      if (ex_md_op == MD_MTLO) lo <= ex_rs;
    end
  end

  assign busy     = (state == ST_BUSY);
  assign md_stall = id_is_md && (busy || start);

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// Scoreboard bench for md_ctrl: a reference model queues expected busy/stall
// per cycle and HI/LO results per operation; a monitor pops and compares.
module tb_md_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  ex_md_op = 4'd0;
  logic [31:0] ex_rs = 32'd0;
  logic [31:0] ex_rt = 32'd0;
  logic        id_is_md = 1'b0;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ex_md_op (ex_md_op),
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .id_is_md (id_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { bit busy; bit stall; }                   cyc_exp_t;
  typedef struct { int n; logic [31:0] hi; logic [31:0] lo; } md_exp_t;
  typedef struct { int due; logic [31:0] hi; logic [31:0] lo; } chk_exp_t;

  cyc_exp_t cq[$];
  md_exp_t  mdq[$];
  chk_exp_t chkq[$];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_rem = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // monitor state, cleared whenever reset is applied
  bit mon_prev_busy = 1'b0;
  int mon_run = 0;
  always @(negedge reset_n) begin
    mon_prev_busy = 1'b0;
    mon_run = 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] rs,
                                           input logic [31:0] rt);
    longint a, b, q, r;
    logic [63:0] res;
    res = 64'd0;
    case (op)
      MD_MULT:  begin a = $signed(rs); b = $signed(rt); res = a * b; end
      MD_MULTU: res = {32'd0, rs} * {32'd0, rt};
      MD_DIV:   begin a = $signed(rs); b = $signed(rt); q = a / b; r = a % b;
                      res = {r[31:0], q[31:0]}; end
      MD_DIVU:  begin a = {32'd0, rs}; b = {32'd0, rt}; q = a / b; r = a % b;
                      res = {r[31:0], q[31:0]}; end
      default:  res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic id);
    bit idle, arith, st;
    logic [63:0] r;
    int n;
    @(negedge clk);
    ex_md_op = op; ex_rs = rs; ex_rt = rt; id_is_md = id;
    idle  = (m_rem == 0);
    arith = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    st    = idle && arith;
    cq.push_back('{busy: !idle, stall: id && (!idle || st)});
    if (st) begin
      n = ((op == MD_DIV) || (op == MD_DIVU)) ? 10 : 5;
      if (!(((op == MD_DIV) || (op == MD_DIVU)) && rt == 32'd0)) begin
        r = ref_calc(op, rs, rt);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
      mdq.push_back('{n: n, hi: m_hi, lo: m_lo});
      m_rem = n;
    end else begin
      if (idle && op == MD_MTHI) m_hi = rs;
      if (idle && op == MD_MTLO) m_lo = rs;
      if (idle && (op == MD_MTHI || op == MD_MTLO))
        chkq.push_back('{due: cyc_cnt + 1, hi: m_hi, lo: m_lo});
      if (m_rem > 0) m_rem--;
    end
  endtask

  task automatic idle_cycles(input int n, input logic id);
    for (int i = 0; i < n; i++) drive(MD_NONE, $urandom, $urandom, id);
  endtask

  // monitor: samples 2 time units after the falling edge
  initial begin
    cyc_exp_t c;
    md_exp_t  m;
    chk_exp_t k;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (cq.size() > 0) begin
          c = cq.pop_front();
          check("busy", {63'd0, busy}, {63'd0, c.busy});
          check("md_stall", {63'd0, md_stall}, {63'd0, c.stall});
        end
        if (busy) mon_run++;
        if (mon_prev_busy && !busy) begin
          if (mdq.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            m = mdq.pop_front();
            check("busy_len", 64'(mon_run), 64'(m.n));
            check("hilo_result", {hi, lo}, {m.hi, m.lo});
          end
          mon_run = 0;
        end
        while (chkq.size() > 0 && chkq[0].due <= cyc_cnt) begin
          k = chkq.pop_front();
          check("hilo_direct", {hi, lo}, {k.hi, k.lo});
        end
        mon_prev_busy = busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] rs, rt;
    int sel;

    // power-on reset, released between edges so the next edge may start
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    chkq.push_back('{due: cyc_cnt, hi: 32'd0, lo: 32'd0});

    drive(MD_MULT, 32'd3, 32'hFFFF_FFFE, 1'b0);
    idle_cycles(6, 1'b0);
    drive(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle_cycles(6, 1'b0);
    drive(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle_cycles(11, 1'b0);
    // divide by zero with a dependent MFLO waiting in ID
    drive(MD_DIVU, 32'd7, 32'd0, 1'b1);
    idle_cycles(12, 1'b1);
    // non-md instruction in ID while busy, plus ignored requests
    drive(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    drive(MD_DIV, 32'd100, 32'd3, 1'b1);
    idle_cycles(4, 1'b0);
    drive(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    drive(MD_MTLO, 32'h8765_4321, 32'd0, 1'b0);
    drive(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_cycles(11, 1'b0);
    drive(MD_DIV, 32'd7, 32'd0, 1'b0);
    idle_cycles(11, 1'b0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        4, 5:    op = MD_MULT;
        6:       op = MD_MULTU;
        7, 8:    op = MD_DIV;
        9:       op = MD_DIVU;
        10:      op = MD_MTHI;
        11:      op = MD_MTLO;
        default: op = MD_NONE;
      endcase
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 15))
        0:       rt = 32'd0;
        1:       begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2:       rt = $urandom_range(1, 9);
        3:       rt = -$urandom_range(1, 9);
        default: ;
      endcase
      drive(op, rs, rt, 1'($urandom_range(0, 1)));
    end
    idle_cycles(12, 1'b0);

    // asynchronous reset during the third busy cycle of a MULT
    drive(MD_MTLO, 32'hAAAA_5555, 32'd0, 1'b0);
    drive(MD_MULT, 32'd1234, 32'd5678, 1'b0);
    idle_cycles(2, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    mdq.delete();
    m_rem = 0; m_hi = 32'd0; m_lo = 32'd0;
    #2 reset_n = 1'b1;
    chkq.push_back('{due: cyc_cnt, hi: 32'd0, lo: 32'd0});
    idle_cycles(8, 1'b1);
    chkq.push_back('{due: cyc_cnt + 1, hi: 32'd0, lo: 32'd0});
    drive(MD_MULTU, 32'd6, 32'd7, 1'b1);
    idle_cycles(8, 1'b0);

    check("md_queue_drained", 64'(mdq.size()), 64'd0);
    check("chk_queue_drained", 64'(chkq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
